i2c_txn_sched: RTL and testbench

- Upstream command scheduler for the I2C controller top level (master + slave pair).
- Buffers I2C transactions (op, 7-bit addr, data byte) in a command FIFO and issues them one at a time to the controller's newd/op/addr/din inputs.
- Tracks busy/done/ack_err for each issued transaction and returns one response per command (read data, error and timeout flags) over a valid/ready response port.

---
 rtl/i2c_txn_sched.sv | 107 ++++++++++
 tb/tb_i2c_txn_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sched.sv
// i2c_txn_sched: queues I2C commands and issues them one at a time, returning one response per command.
module i2c_txn_sched #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [6:0]               cmd_addr,
  input  logic [7:0]               cmd_data,
  output logic                     newd,
  output logic                     op,
  output logic [6:0]               addr,
  output logic [7:0]               din,
  input  logic [7:0]               dout,
  input  logic                     busy,
  input  logic                     ack_err,
  input  logic                     done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_op,
  output logic [7:0]               rsp_data,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;
  state_t state, state_nx;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [TW-1:0] tcnt;
  logic [15:0] head;
  logic err_seen, push, pop, active, expired, finish;
  assign head = mem[rd_ptr];
  assign cmd_ready = count != (AW+1)'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign pop = state == IDLE && count != '0 && !busy;
  assign active = state == ISSUE || state == WAIT_DONE;
  assign expired = tcnt == TW'(TIMEOUT_CYC - 1);
  assign finish = active && (done || expired);
  assign pending = count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_op, cmd_addr, cmd_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // done outranks both busy and an expiring timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = pop ? ISSUE : IDLE;
      ISSUE:     state_nx = (done || expired) ? RESP : busy ? WAIT_DONE : ISSUE;
      WAIT_DONE: state_nx = (done || expired) ? RESP : WAIT_DONE;
      default:   state_nx = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_comb begin
    newd = state == ISSUE;
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= 1'b0;
      addr <= '0;
      din <= '0;
      tcnt <= '0;
      err_seen <= 1'b0;
      rsp_op <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (pop) begin
        op <= head[15];
        addr <= head[14:8];
        din <= head[15] ? 8'h00 : head[7:0];
        tcnt <= '0;
        err_seen <= 1'b0;
      end else if (active) begin
        tcnt <= tcnt + TW'(1);
        err_seen <= err_seen | ack_err;
      end
      if (finish) begin
        rsp_op <= op;
        rsp_data <= done && op ? dout : 8'h00;
        rsp_err <= err_seen | ack_err;
        rsp_timeout <= !done;
      end
    end
  end
endmodule

// File: tb/tb_i2c_txn_sched.sv
// tb_i2c_txn_sched: directed table, corner sequences and random traffic against a queue-based reference.
module tb_i2c_txn_sched;
  localparam int DEPTH = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, cmd_op, newd, op;
  logic [6:0] cmd_addr, addr;
  logic [7:0] cmd_data, din, dout, rsp_data;
  logic busy, busy_c, stall, ack_err, done;
  logic rsp_valid, rsp_ready, rsp_op, rsp_err, rsp_timeout;
  logic [$clog2(DEPTH):0] pending;
  assign busy = busy_c | stall;
  always #5 clk = ~clk;

  i2c_txn_sched #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .newd(newd), .op(op), .addr(addr), .din(din),
    .dout(dout), .busy(busy), .ack_err(ack_err), .done(done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .pending(pending)
  );

  typedef struct {
    logic op;
    logic [6:0] addr;
    logic [7:0] din;
    logic [7:0] rdata;
    logic err;
    logic to;
  } txn_t;
  txn_t iq[$];
  txn_t rq[$];

  typedef struct {
    logic op;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp_din;
    logic [7:0] exp_rdata;
    logic exp_err;
  } vec_t;
  vec_t tbl[6];

  int errors = 0;
  int checks = 0;
  bit act, hang;
  int c, d, b;
  logic [6:0] cur_addr;
  logic cur_op, nb, nd, na;
  logic [7:0] ndout;

  function automatic logic [7:0] rd_byte(input logic [6:0] a);
    return a == 7'h50 ? 8'h3C : {1'b0, a} ^ 8'h96;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference: commands queue at handshake, leave iq on issue and rq on response
  task automatic monitor;
    txn_t t, e;
    if (!rst && !act && newd) begin
      if (iq.size() == 0) chk("issue unexpected", newd, 0);
      else begin
        e = iq.pop_front();
        chk("issue op", op, e.op);
        chk("issue addr", addr, e.addr);
        chk("issue din", din, e.din);
      end
      act = 1;
      c = 0;
      d = $urandom_range(0, 2);
      b = $urandom_range(0, 6);
      cur_addr = addr;
      cur_op = op;
    end
    chk("pending", pending, iq.size());
    nb = 0;
    nd = 0;
    na = 0;
    if (rst) begin
      iq.delete();
      rq.delete();
      act = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        t.op = cmd_op;
        t.addr = cmd_addr;
        t.din = cmd_op ? 8'h00 : cmd_data;
        t.rdata = (cmd_op && !hang) ? rd_byte(cmd_addr) : 8'h00;
        t.err = !hang && cmd_addr == 7'h7F;
        t.to = hang;
        iq.push_back(t);
        rq.push_back(t);
      end
      if (rsp_valid && rsp_ready) begin
        if (rq.size() == 0) chk("rsp unexpected", rsp_valid, 0);
        else begin
          e = rq.pop_front();
          chk("rsp op", rsp_op, e.op);
          chk("rsp data", rsp_data, e.rdata);
          chk("rsp err", rsp_err, e.err);
          chk("rsp timeout", rsp_timeout, e.to);
        end
      end
      if (act) begin
        c++;
        if (hang) nb = 1;
        else if (c > d + b + 1) act = 0;
        else begin
          nb = c > d && c <= d + b;
          nd = c == d + b + 1;
          na = cur_addr == 7'h7F && c == ((d + b) < 1 ? 1 : d + b);
        end
      end
    end
    ndout = (nd && cur_op) ? rd_byte(cur_addr) : 8'($urandom);
  endtask

  task automatic tick;
    monitor();
    @(posedge clk);
    #1;
    busy_c = nb;
    done = nd;
    ack_err = na;
    dout = ndout;
    @(negedge clk);
  endtask

  task automatic push(input logic o, input logic [6:0] a, input logic [7:0] dd);
    int n = 0;
    cmd_valid = 1;
    cmd_op = o;
    cmd_addr = a;
    cmd_data = dd;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    chk("push ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_newd;
    int n = 0;
    while (!newd && n < 50) begin tick(); n++; end
    chk("wait newd", newd, 1);
  endtask

  task automatic wait_rsp;
    int n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    chk("wait rsp", rsp_valid, 1);
  endtask

  task automatic drain;
    int n = 0;
    rsp_ready = 1;
    while ((rq.size() != 0 || rsp_valid) && n < 3000) begin tick(); n++; end
    chk("drain", rq.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    chk({tag, " ctl outs"}, {newd, op, addr, din}, 0);
    chk({tag, " rsp outs"}, {rsp_valid, rsp_op, rsp_data, rsp_err, rsp_timeout}, 0);
    chk({tag, " pending"}, pending, 0);
  endtask

  initial begin
    logic [11:0] snap;
    int n;
    tbl[0] = '{1'b0, 7'h50, 8'hA5, 8'hA5, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 7'h50, 8'h77, 8'h00, 8'h3C, 1'b0};
    tbl[2] = '{1'b0, 7'h7F, 8'h11, 8'h11, 8'h00, 1'b1};
    tbl[3] = '{1'b1, 7'h12, 8'hFF, 8'h00, 8'h84, 1'b0};
    tbl[4] = '{1'b1, 7'h7F, 8'h00, 8'h00, 8'hE9, 1'b1};
    tbl[5] = '{1'b0, 7'h00, 8'hFF, 8'hFF, 8'h00, 1'b0};
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; rsp_ready = 0;
    busy_c = 0; stall = 0; ack_err = 0; done = 0; dout = 0;
    act = 0; hang = 0; c = 0; d = 0; b = 0; cur_addr = 0; cur_op = 0;
    nb = 0; nd = 0; na = 0; ndout = 0;
    @(posedge clk);
    @(negedge clk);
    tick();
    rst = 0;
    check_reset("reset");

    for (int i = 0; i < 6; i++) begin
      rsp_ready = 0;
      cmd_valid = 1; cmd_op = tbl[i].op; cmd_addr = tbl[i].addr; cmd_data = tbl[i].data;
      tick();
      cmd_valid = 0;
      chk("tbl newd early", newd, 0);
      tick();
      chk("tbl newd", newd, 1);
      chk("tbl op", op, tbl[i].op);
      chk("tbl addr", addr, tbl[i].addr);
      chk("tbl din", din, tbl[i].exp_din);
      wait_rsp();
      chk("tbl rsp_op", rsp_op, tbl[i].op);
      chk("tbl rsp_data", rsp_data, tbl[i].exp_rdata);
      chk("tbl rsp_err", rsp_err, tbl[i].exp_err);
      chk("tbl rsp_timeout", rsp_timeout, 0);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("tbl rsp_valid drop", rsp_valid, 0);
    end

    // consumer stalls: response held, nothing new issued
    push(1'b1, 7'h12, 8'h00);
    push(1'b0, 7'h33, 8'hAA);
    wait_rsp();
    snap = {rsp_op, rsp_data, rsp_err, rsp_timeout, rsp_valid};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold rsp", {rsp_op, rsp_data, rsp_err, rsp_timeout, rsp_valid}, snap);
      chk("hold newd", newd, 0);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("after hs newd", newd, 0);
    tick();
    chk("next issue newd", newd, 1);
    drain();

    // controller stalled busy: fill the FIFO, then release
    stall = 1;
    for (int i = 1; i <= DEPTH; i++) push(1'b1, 7'(i), 8'h00);
    chk("full cmd_ready", cmd_ready, 0);
    chk("full pending", pending, DEPTH);
    cmd_valid = 1; cmd_op = 1; cmd_addr = 7'(DEPTH + 1); cmd_data = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("full held", pending, DEPTH);
    stall = 0;
    push(1'b1, 7'(DEPTH + 1), 8'h00);
    drain();

    // timeout: controller busy forever
    rsp_ready = 0;
    hang = 1;
    push(1'b0, 7'h22, 8'h5A);
    wait_newd();
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    chk("timeout cycles", n, TO);
    chk("timeout flag", rsp_timeout, 1);
    chk("timeout data", rsp_data, 0);
    chk("timeout newd", newd, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    hang = 0;
    tick();

    // reset while waiting for done
    hang = 1;
    push(1'b0, 7'h44, 8'h01);
    push(1'b1, 7'h45, 8'h00);
    wait_newd();
    for (int i = 0; i < 3; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    hang = 0;
    check_reset("mid reset");
    tick();

    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom % 3) == 0;
      cmd_op = 1'($urandom);
      cmd_addr = ($urandom % 4 == 0) ? 7'h7F : 7'($urandom);
      cmd_data = 8'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      tick();
    end
    cmd_valid = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
